// File: rtl/k_sync_fifo_ram.sv
// Single-clock FIFO over a dual-port word array with registered read data,
// level flags derived from wrap-bit pointers, and one-cycle over/underflow pulses.
module k_sync_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int AF_LVL = (1 << ADDR_W) - 1,
    parameter int AE_LVL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_CNT = (ADDR_W + 1)'(AE_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              wr_accept;
    logic              rd_accept;

    // Flags come straight from the pointers, so they move on the same edge as the pointers.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                          (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A read frees a slot in the same cycle, so a full FIFO can still take a write.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    // NOTE: the array has no reset; stale words are unreachable because the pointers reset equal.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid  <= rd_accept;
            overflow  <= wr_en && !wr_accept;
            underflow <= rd_en && !rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_k_sync_fifo_ram.sv
// Directed bench for k_sync_fifo_ram: a queue model predicts every output each cycle,
// and named checks cover reset, fill/drain, overflow, underflow, wrap and mid-run reset.
module tb_k_sync_fifo_ram;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] sb_q[$];
    logic [DATA_W-1:0] last_rd = '0;

    k_sync_fifo_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .AF_LVL(3),
        .AE_LVL(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".count"}, 32'(count), 0);
        check({tag, ".empty"}, 32'(empty), 1);
        check({tag, ".almost_empty"}, 32'(almost_empty), 1);
        check({tag, ".full"}, 32'(full), 0);
        check({tag, ".almost_full"}, 32'(almost_full), 0);
        check({tag, ".rd_data"}, 32'(rd_data), 0);
        check({tag, ".rd_valid"}, 32'(rd_valid), 0);
        check({tag, ".overflow"}, 32'(overflow), 0);
        check({tag, ".underflow"}, 32'(underflow), 0);
    endtask

    // One clock cycle: predict acceptance from the model, drive, then compare every output.
    task automatic do_cycle(input string tag, input logic wr, input logic [DATA_W-1:0] d, input logic rd);
        logic rd_acc, wr_acc, exp_ovf, exp_udf;
        int   lvl;
        rd_acc  = rd && (sb_q.size() != 0);
        wr_acc  = wr && ((sb_q.size() != DEPTH) || rd_acc);
        exp_ovf = wr && !wr_acc;
        exp_udf = rd && !rd_acc;
        if (rd_acc) last_rd = sb_q.pop_front();
        if (wr_acc) sb_q.push_back(d);
        lvl = sb_q.size();

        @(negedge clk);
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        @(posedge clk);
        #1;
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(rd_acc));
        check({tag, ".rd_data"}, 32'(rd_data), 32'(last_rd));
        check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(exp_udf));
        check({tag, ".count"}, 32'(count), 32'(lvl));
        check({tag, ".full"}, 32'(full), 32'(lvl == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(lvl == 0));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(lvl >= 3));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(lvl <= 1));
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;

        // Reset state before any clock edge.
        #2;
        check_idle_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill and drain.
        do_cycle("fill0", 1'b1, 8'h11, 1'b0);
        do_cycle("fill1", 1'b1, 8'h22, 1'b0);
        do_cycle("fill2", 1'b1, 8'h33, 1'b0);
        do_cycle("fill3", 1'b1, 8'h44, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle("drain", 1'b0, 8'h00, 1'b1);

        // Underflow on empty: rd_data must hold 0x44.
        do_cycle("udf", 1'b0, 8'h00, 1'b1);
        check("udf.hold44", 32'(rd_data), 32'h44);
        do_cycle("udf_clear", 1'b0, 8'h00, 1'b0);

        // Overflow on full: 0x55 must never come out.
        do_cycle("ovf_fill0", 1'b1, 8'h11, 1'b0);
        do_cycle("ovf_fill1", 1'b1, 8'h22, 1'b0);
        do_cycle("ovf_fill2", 1'b1, 8'h33, 1'b0);
        do_cycle("ovf_fill3", 1'b1, 8'h44, 1'b0);
        do_cycle("ovf", 1'b1, 8'h55, 1'b0);
        do_cycle("ovf_clear", 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_cycle("ovf_drain", 1'b0, 8'h00, 1'b1);
            check("ovf_drain.not55", 32'(rd_data != 8'h55), 1);
        end

        // Simultaneous read+write on empty, then on full.
        do_cycle("sim_empty", 1'b1, 8'hA0, 1'b1);
        do_cycle("sim_fill1", 1'b1, 8'hA1, 1'b0);
        do_cycle("sim_fill2", 1'b1, 8'hA2, 1'b0);
        do_cycle("sim_fill3", 1'b1, 8'hA3, 1'b0);
        do_cycle("sim_full", 1'b1, 8'hB0, 1'b1);
        check("sim_full.oldest", 32'(rd_data), 32'hA0);
        for (int i = 0; i < 4; i++) do_cycle("sim_drain", 1'b0, 8'h00, 1'b1);

        // Wrap-around with interleaved write/read pairs.
        for (int i = 0; i < 10; i++) begin
            do_cycle("wrap_wr", 1'b1, 8'(i), 1'b0);
            check("wrap.count_le2", 32'(count <= 2), 1);
            do_cycle("wrap_rd", 1'b0, 8'h00, 1'b1);
            check("wrap.seq", 32'(rd_data), 32'(i));
        end

        // Asynchronous reset mid-operation with three words stored.
        do_cycle("ar_fill0", 1'b1, 8'h71, 1'b0);
        do_cycle("ar_fill1", 1'b1, 8'h72, 1'b0);
        do_cycle("ar_fill2", 1'b1, 8'h73, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_reset("async_rst");
        wr_en   = 1'b1;
        wr_data = 8'hFF;
        rd_en   = 1'b1;
        @(posedge clk);
        #1;
        check_idle_reset("rst_ignore");
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst_n = 1'b1;
        sb_q.delete();
        last_rd = '0;
        do_cycle("post_rst_wr", 1'b1, 8'hC3, 1'b0);
        do_cycle("post_rst_rd", 1'b0, 8'h00, 1'b1);
        check("post_rst.C3", 32'(rd_data), 32'hC3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/k_sync_fifo_ram.md
K_SYNC_FIFO_RAM -- requirements
Module: k_sync_fifo_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 2, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter AF_LVL, default DEPTH-1, almost_full asserts when count >= AF_LVL.
REQ-004 SHALL have parameter AE_LVL, default 1, almost_empty asserts when count <= AE_LVL.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port wr_data  input  DATA_W  write word.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port rd_data  output  DATA_W  registered read word.
REQ-011 SHALL have port rd_valid  output  1  rd_data updated this cycle.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port empty  output  1  count == 0.
REQ-014 SHALL have port almost_full  output  1  count >= AF_LVL.
REQ-015 SHALL have port almost_empty  output  1  count <= AE_LVL.
REQ-016 SHALL have port count  output  ADDR_W+1  words currently stored, 0..DEPTH.
REQ-017 SHALL have port overflow  output  1  one-cycle pulse: write rejected.
REQ-018 SHALL have port underflow  output  1  one-cycle pulse: read rejected.

Function
REQ-019 SHALL store data in an internal DEPTH x DATA_W dual-port array: one write port, one read port, both clocked by clk.
REQ-020 SHALL keep wr_ptr and rd_ptr of ADDR_W+1 bits; array index = low ADDR_W bits; MSB toggles on wrap from DEPTH-1 to 0.
REQ-021 SHALL derive full = (ptr MSBs differ, low bits equal) and empty = (ptrs equal); count = wr_ptr - rd_ptr modulo 2**(ADDR_W+1).
REQ-022 SHALL accept a write when wr_en=1 and (full=0 or a read is accepted in the same cycle); accepted write stores wr_data at wr_ptr and increments wr_ptr.
REQ-023 SHALL accept a read when rd_en=1 and empty=0; accepted read loads mem[rd_ptr] into rd_data at the same edge, increments rd_ptr, and sets rd_valid=1 for the following cycle.
REQ-024 SHALL hold rd_data unchanged and drive rd_valid=0 in any cycle after which no read was accepted.
REQ-025 SHALL treat simultaneous read and write when empty: write accepted, read rejected; underflow pulses; no write-through of wr_data to rd_data.
REQ-026 SHALL treat simultaneous read and write when full: both accepted; count stays DEPTH; overflow stays 0.
REQ-027 SHALL treat simultaneous accepted read and write at any other level: count unchanged, both pointers advance.
REQ-028 SHALL pulse overflow for exactly one cycle after a rejected write; memory, wr_ptr, count unchanged.
REQ-029 SHALL pulse underflow for exactly one cycle after a rejected read; rd_data, rd_ptr, count unchanged.
REQ-030 SHALL update full, empty, almost_full, almost_empty, count at the same edge as the pointer change (flags consistent with count every cycle, no extra latency).
REQ-031 SHALL require AE_LVL < AF_LVL <= DEPTH; behaviour outside this range is undefined.

Reset
REQ-032 SHALL, on rst_n low, immediately and without waiting for clk: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
REQ-033 SHALL not require memory contents to be cleared by reset; stale contents are never readable, since empty=1.
REQ-034 SHALL, on rst_n asserted mid-operation, discard all stored words; first read after release returns the first word written after release.
REQ-035 SHALL ignore wr_en and rd_en while rst_n is low; operation resumes at the first rising clk edge with rst_n high.

Verification (DATA_W=8, ADDR_W=2, AF_LVL=3, AE_LVL=1)
REQ-036 SHALL cover fill and drain: write 0x11,0x22,0x33,0x44 -> count 1..4, almost_full at count 3, full at 4; read 4x -> rd_data 0x11,0x22,0x33,0x44, each with rd_valid=1, then empty=1.
REQ-037 SHALL cover overflow: with full=1, write 0x55 with rd_en=0 -> overflow=1 for one cycle, count=4; subsequent reads return 0x11..0x44, never 0x55.
REQ-038 SHALL cover underflow: with empty=1, rd_en=1 -> underflow=1 for one cycle, rd_valid=0, rd_data holds its last value.
REQ-039 SHALL cover simultaneous ops: on empty, wr 0xA0 + rd -> count=1, underflow=1; on full, wr 0xB0 + rd -> oldest word out, count=4, overflow=0.
REQ-040 SHALL cover wrap-around: 10 interleaved write/read pairs of 0x00..0x09 -> rd_data sequence 0x00..0x09 in order across pointer wrap, count never exceeds 2.
REQ-041 SHALL cover asynchronous reset: with count=3, drop rst_n between clk edges -> count=0, empty=1 before the next edge; write 0xC3 then read -> rd_data=0xC3.
